uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte FIFO sitting directly upstream of the `uart` transmit port. It absorbs bursts from a byte producer (DIP/pushbutton logic, command responder) and presents them to the UART `in_valid`/`in_ready`/`in_data` handshake one byte at a time, with first-word-fall-through output. A sticky overflow flag records producer bytes offered while the FIFO was full, for LED display.

## Interface
- `WIDTH`, 8: data width in bits.
- `DEPTH_LOG2`, 4: log2 of storage depth (default 16 entries); legal range 1..10.

- `main_clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  producer offers `wr_data` this cycle.
- `wr_data`  in  WIDTH  producer byte.
- `wr_ready`  out  1  FIFO can accept a byte this cycle.
- `out_valid`  out  1  head byte available; drives UART `in_valid`.
- `out_data`  out  WIDTH  head byte; drives UART `in_data`.
- `out_ready`  in  1  UART accepts; driven by UART `in_ready`.
- `overflow`  out  1  sticky: a byte was offered while `wr_ready` = 0.
- `clr_overflow`  in  1  synchronous clear of `overflow`.
- `level`  out  DEPTH_LOG2+1  occupancy (only with `UART_TX_FIFO_LEVEL_EN`).

## Operation
- Write accepted when `wr_valid & wr_ready` at a clock edge; read (pop) when `out_valid & out_ready`.
- `wr_ready` = (count != 2^DEPTH_LOG2), from registered count only; no read-through-full bypass.
- `out_valid` = (count != 0); `out_data` = entry at read pointer (registered storage, combinational mux from pointer).
- Pointers DEPTH_LOG2 bits, wrap modulo depth; count DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.
- Simultaneous accepted write and pop: both pointers advance, count unchanged. Never both possible when empty (no write-to-read bypass) or when full (write refused).
- Holding `out_data`: stable while `out_valid & !out_ready`.
- `overflow` set on any cycle `wr_valid & !wr_ready`; cleared by `clr_overflow`; set wins if both in same cycle.
- Storage contents not reset; only pointers, count, `overflow` reset.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): pointers 0, count 0, `wr_ready` 1, `out_valid` 0, `overflow` 0, `level` 0; `out_data` undefined until first write.
- Write-to-output latency: byte written at edge N visible with `out_valid` = 1 after edge N (available for pop at edge N+1).
- Pop takes effect at the edge; next byte on `out_data` immediately after.
- Full to not-full: `wr_ready` rises the cycle after the pop edge.
- Reset mid-transfer: all queued bytes discarded; a byte the UART accepted at the same edge as reset deassertion is not re-presented.

## Configuration
- `UART_TX_FIFO_LEVEL_EN` defined: `level` port exists and equals count.
- Undefined: `level` port absent; behaviour otherwise identical.

## Structure
- Shared package `uart_pkg`: `UART_BYTE_W` (8) constant and a byte typedef; used here and by `uart`.
- One sub-module `fifo_ram`: 2^DEPTH_LOG2 x WIDTH register array, one synchronous write port, one asynchronous read port. Pointer/count/flag control stays in `uart_tx_fifo`.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 with `out_ready` = 0 -> `out_valid` 1, `out_data` 0x11 held, count 3; raise `out_ready` -> 0x11, 0x22, 0x33 on consecutive edges, then `out_valid` 0.
- Write 16 bytes 0x00..0x0F with `out_ready` = 0 -> `wr_ready` 0 after 16th; offer 0xAA -> refused, `overflow` 1; drain -> 0x00..0x0F in order, 0xAA absent.
- Full FIFO, `wr_valid` and `out_ready` both high -> pop occurs, write refused that cycle, `wr_ready` 1 next cycle, count 15.
- Half-full (8), continuous write and pop for 40 cycles -> count stays 8, pointers wrap, output order matches input.
- `clr_overflow` and overflowing write same cycle -> `overflow` remains 1; `clr_overflow` alone -> 0.
- Assert `reset` with 5 bytes queued -> `out_valid` 0, `wr_ready` 1, `overflow` 0 immediately (no clock edge needed).

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART transmitter and the
// byte FIFO that feeds it.
//   UART_BYTE_W : width of one UART character in bits
//   uart_byte_t : one UART character
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: 2^AW x WIDTH register array for the transmit FIFO.
// One synchronous write port and one asynchronous read port, so the FIFO
// head can fall through to its output without a read-latency cycle.
// The storage has no reset; its contents are undefined until written.
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read data at raddr
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO in front of the UART
// transmit handshake, with a sticky overflow flag for LED display.
// Optional feature macro: UART_TX_FIFO_LEVEL_EN adds the `level` output.
// Ports:
//   main_clk      in   system clock, all state on rising edge
//   reset         in   asynchronous active-low reset
//   wr_valid      in   producer offers wr_data
//   wr_data       in   producer byte
//   wr_ready      out  FIFO has room (from registered count only)
//   out_valid     out  head byte present (UART in_valid)
//   out_data      out  head byte (UART in_data)
//   out_ready     in   UART accepts head byte (UART in_ready)
//   overflow      out  sticky: a byte was offered while full
//   clr_overflow  in   synchronous clear of overflow (set has priority)
//   level         out  occupancy, only with UART_TX_FIFO_LEVEL_EN
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH      = UART_BYTE_W,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  main_clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic                  overflow,
`ifdef UART_TX_FIFO_LEVEL_EN
  input  logic                  clr_overflow,
  output logic [DEPTH_LOG2:0]   level
`else
  input  logic                  clr_overflow
`endif
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  overflow_reg;
  logic                  wr_fire;
  logic                  rd_fire;

  // Flow control comes only from the registered count: a pop in the same
  // cycle does not make room for a write while full, and a write does not
  // bypass to the output while empty.
  assign wr_ready  = (count_reg != FULL_CNT);
  assign out_valid = (count_reg != '0);
  assign wr_fire   = wr_valid & wr_ready;
  assign rd_fire   = out_valid & out_ready;
  assign overflow  = overflow_reg;

  always_comb begin
    count_next = count_reg;
    if (wr_fire && !rd_fire) begin
      count_next = count_reg + (DEPTH_LOG2+1)'(1);
    end else if (rd_fire && !wr_fire) begin
      count_next = count_reg - (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      end
      count_reg <= count_next;
      // A refused offer in the same cycle as a clear keeps the flag set.
      if (wr_valid && !wr_ready) begin
        overflow_reg <= 1'b1;
      end else if (clr_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .clk   (main_clk),
    .we    (wr_fire),
    .waddr (wr_ptr_reg),
    .wdata (wr_data),
    .raddr (rd_ptr_reg),
    .rdata (out_data)
  );

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = count_reg;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo
// (default parameters: 8-bit data, 16 entries).
module tb_uart_tx_fifo;

  localparam int DL = 4;

  logic          main_clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready = 1'b0;
  logic          overflow;
  logic          clr_overflow = 1'b0;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [DL:0]   level;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 main_clk = ~main_clk;

  uart_tx_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DL)
  ) dut (
    .main_clk     (main_clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .overflow     (overflow),
`ifdef UART_TX_FIFO_LEVEL_EN
    .clr_overflow (clr_overflow),
    .level        (level)
`else
    .clr_overflow (clr_overflow)
`endif
  );

  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        ordy;
    logic        clr;
    logic        e_wr_ready;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_data_chk;
    logic        e_ovf;
    logic [DL:0] e_level;
  } vec_t;

  vec_t vt [7];

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge main_clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic chk_level(input string name, input logic [DL:0] exp);
`ifdef UART_TX_FIFO_LEVEL_EN
    n_checks++;
    if (level !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, level, exp);
    end else begin
      $display("ok   %s: %0d", name, level);
    end
`else
    if (exp > (DL+1)'(16)) $display("note %s: level out of range", name);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //              wv    wd     ordy  clr   wrdy  vld   data   dchk  ovf   lvl
    vt[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 5'd1};
    vt[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 5'd2};
    vt[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 5'd3};
    vt[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 5'd3};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 5'd2};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 5'd1};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};

    // Reset state
    step();
    step();
    chk1("reset wr_ready", wr_ready, 1'b1);
    chk1("reset out_valid", out_valid, 1'b0);
    chk1("reset overflow", overflow, 1'b0);
    chk_level("reset level", 5'd0);
    reset = 1'b1;
    step();

    // Three writes held, then drained on consecutive edges
    for (int i = 0; i < 7; i++) begin
      wr_valid     = vt[i].wv;
      wr_data      = vt[i].wd;
      out_ready    = vt[i].ordy;
      clr_overflow = vt[i].clr;
      step();
      chk1($sformatf("vec%0d wr_ready", i), wr_ready, vt[i].e_wr_ready);
      chk1($sformatf("vec%0d out_valid", i), out_valid, vt[i].e_valid);
      if (vt[i].e_data_chk) chk8($sformatf("vec%0d out_data", i), out_data, vt[i].e_data);
      chk1($sformatf("vec%0d overflow", i), overflow, vt[i].e_ovf);
      chk_level($sformatf("vec%0d level", i), vt[i].e_level);
    end
    wr_valid = 1'b0;
    out_ready = 1'b0;

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      step();
      chk1($sformatf("fill%0d wr_ready", i), wr_ready, (i != 15));
    end
    chk_level("full level", 5'd16);

    // Offer while full -> refused, overflow set, head unchanged
    wr_data = 8'hAA;
    step();
    chk1("full offer overflow", overflow, 1'b1);
    chk1("full offer wr_ready", wr_ready, 1'b0);
    chk8("full offer head", out_data, 8'h00);

    // Clear and overflowing write in the same cycle: set wins
    wr_data = 8'hCC;
    clr_overflow = 1'b1;
    step();
    chk1("clr+ovf overflow", overflow, 1'b1);
    wr_valid = 1'b0;
    step();
    chk1("clr alone overflow", overflow, 1'b0);
    clr_overflow = 1'b0;

    // Full, write and pop together: pop happens, write refused
    wr_valid  = 1'b1;
    wr_data   = 8'hBB;
    out_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    chk1("full both wr_ready", wr_ready, 1'b1);
    chk8("full both head", out_data, 8'h01);
    chk1("full both overflow", overflow, 1'b1);
    chk_level("full both level", 5'd15);

    // Drain the rest; refused bytes must not appear
    for (int i = 1; i < 16; i++) begin
      chk1($sformatf("drain%0d valid", i), out_valid, 1'b1);
      chk8($sformatf("drain%0d data", i), out_data, 8'(i));
      step();
    end
    chk1("drain empty valid", out_valid, 1'b0);
    out_ready = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;

    // Half full, then 40 cycles of simultaneous write and pop
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h40 + i);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_data = 8'(8'h48 + k);
      chk8($sformatf("stream%0d data", k), out_data, 8'(8'h40 + k));
      step();
    end
    wr_valid = 1'b0;
    chk1("stream valid", out_valid, 1'b1);
    chk1("stream wr_ready", wr_ready, 1'b1);
    chk_level("stream level", 5'd8);
    for (int k = 40; k < 48; k++) begin
      chk8($sformatf("tail%0d data", k), out_data, 8'(8'h40 + k));
      step();
    end
    chk1("tail empty valid", out_valid, 1'b0);
    out_ready = 1'b0;

    // Five queued with overflow set, then asynchronous reset
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h80 + i);
      step();
    end
    wr_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    out_ready = 1'b0;
    chk8("pre-reset head", out_data, 8'h8B);
    chk1("pre-reset overflow", overflow, 1'b1);
    chk_level("pre-reset level", 5'd5);
    #2;
    reset = 1'b0;
    #1;
    chk1("async reset valid", out_valid, 1'b0);
    chk1("async reset wr_ready", wr_ready, 1'b1);
    chk1("async reset overflow", overflow, 1'b0);
    chk_level("async reset level", 5'd0);
    step();
    reset = 1'b1;
    step();
    chk1("post-reset valid", out_valid, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    step();
    wr_valid = 1'b0;
    chk1("post-reset write valid", out_valid, 1'b1);
    chk8("post-reset write data", out_data, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
